uart_flit_assembler: RTL and testbench
======================================

Name: uart_flit_assembler

Overview:
- Sits between uart_rx and the rx flit buffer. Collects the 16 bytes of one flit_t from the UART byte stream and validates the checksum.
- Discards NOPE flits, stalled partial flits and bad-checksum flits. Presents good flits on a valid/ready interface to the buffer writer.
- Single-entry output register. Overflow is reported with signal_t RX_BUFFER_OVERFLOW.

Parameters:
- TIMEOUT_CYCLES, 20000: maximum idle cycles between bytes inside a flit before the partial flit is discarded (about 2 byte times at CPU_CLK_DIV).
- BYTES_PER_FLIT, FLIT_WIDTH/8 = 16: bytes per flit. Fixed; not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  byte from uart_rx.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- flit_out  out  flit_t (128)  assembled flit.
- flit_valid  out  1  flit_out holds a good flit.
- flit_ready  in  1  consumer accepts when flit_valid && flit_ready.
- err  out  signal_t (32)  one-cycle error pulse; NO_ERROR otherwise.
- chk_err_cnt  out  16  saturating count of checksum failures (see Optional Feature).
- timeout_cnt  out  16  saturating count of timeouts (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state ASM_IDLE; byte_idx 0; shift register 0; flit_out 0; flit_valid 0; err NO_ERROR; counters 0; timer 0. Reset mid-flit or mid-hold drops all content.
- Byte order: MSB first. Byte k goes into bits [127-8k : 120-8k]; the shift register shifts left by 8 per accepted byte.
- Checksum: the 16-bit wrap-around sum of the seven 16-bit words at bits [127:16]. It must equal bits [15:0].
- State ASM_IDLE:
  - rx_valid stores byte 0, sets byte_idx to 1, clears the timer, then go to ASM_RECV.
- State ASM_RECV:
  - Each rx_valid stores a byte, increments byte_idx and clears the timer.
  - The 16th byte (byte_idx 15 when accepted) moves to ASM_CHECK.
  - Without rx_valid the timer increments. At timer == TIMEOUT_CYCLES-1: discard, go to ASM_IDLE, timeout event.
- State ASM_CHECK (exactly one cycle), then always back to ASM_IDLE:
  - Checksum mismatch: drop, checksum event.
  - Checksum match and flittype == NOPE: drop silently.
  - Otherwise, if the output slot is free, or is being accepted this same cycle (flit_valid && flit_ready): load flit_out and set flit_valid next cycle.
  - Otherwise (slot occupied, not accepted): drop the new flit, err = RX_BUFFER_OVERFLOW for one cycle. The held flit is kept unchanged.
  - rx_valid during ASM_CHECK is taken as byte 0 of the next flit (byte_idx becomes 1, next state ASM_RECV).
- Latency: 16th rx_valid at cycle N → flit_valid high at cycle N+2.
- Output handshake:
  - flit_valid stays high and flit_out stays stable until flit_ready.
  - flit_valid drops the cycle after acceptance, unless a new flit loads in the same cycle.
- err: GENERAL_FATAL_ERROR is never driven. Checksum and timeout events do not drive err; they go only to the counters.

Optional Feature:
- Macro FLIT_ASM_STATS_EN.
- Defined: chk_err_cnt and timeout_cnt increment by 1 on each event and saturate at 0xFFFF. They are cleared only by rst.
- Undefined: both ports are tied to 16'h0000 and no counter flops are built. All other behaviour is identical.

Decomposition:
- Package types gains:
  - asm_state_t enum {ASM_IDLE, ASM_RECV, ASM_CHECK}.
  - FLIT_BYTES = FLIT_WIDTH/8.
  - Function calc_checksum(flit_t) returning checksum_t.
- The function is shared with the future tx serializer.
- One sub-module: flit_checksum. Combinational wrapper around calc_checksum, instantiated for the ASM_CHECK compare.

Test Plan:
- Good flit: 16 bytes 0x10, 0x00×13, 0x10, 0x00 with flit_ready=1. Expect flit_valid at N+2 with flit_out = 128'h1000_0000…_1000 (HEAD, version 1). Expect err = NO_ERROR.
- Bad checksum: same bytes with last two 0x10, 0x01. Expect no flit_valid; chk_err_cnt 0→1 (STATS_EN); err stays 0.
- Timeout: 7 bytes, then TIMEOUT_CYCLES idle cycles, then the full good flit. Expect the first partial flit dropped, timeout_cnt = 1, and the good flit delivered intact.
- Backpressure and overflow: flit_ready=0, two good flits sent back-to-back.
  - Expect the first flit held.
  - Expect err = 32'h1 for one cycle at the second flit's ASM_CHECK.
  - Raising flit_ready returns the first flit; no second flit follows.
- Simultaneous accept: flit_ready pulses high on the same cycle as the second flit's ASM_CHECK. Expect the second flit loaded with flit_valid continuously high and no error.
- NOPE filter and async reset: a good flit with flittype NOPE (byte0 = 0x13, checksum 0x1300) gives no flit_valid. Asserting rst after byte 9 gives all outputs 0 immediately; a full flit afterwards assembles correctly.

Source files
------------

// File: rtl/uart_flit_assembler_pkg.sv
// rtl/uart_flit_assembler_pkg.sv - flit, error-signal and assembler state types shared by rx assembly and tx serialisation
package uart_flit_assembler_pkg;

    localparam int FLIT_WIDTH = 128;
    localparam int FLIT_BYTES = FLIT_WIDTH / 8;

    typedef logic [FLIT_WIDTH-1:0] flit_t;
    typedef logic [15:0]           checksum_t;

    // Byte 0 of a flit is {version[3:0], flittype[3:0]}.
    typedef enum logic [3:0] {
        HEAD = 4'h0,
        BODY = 4'h1,
        TAIL = 4'h2,
        NOPE = 4'h3
    } flittype_t;

    typedef enum logic [31:0] {
        NO_ERROR            = 32'h0000_0000,
        RX_BUFFER_OVERFLOW  = 32'h0000_0001,
        GENERAL_FATAL_ERROR = 32'hFFFF_FFFF
    } signal_t;

    typedef enum logic [1:0] {
        ASM_IDLE,
        ASM_RECV,
        ASM_CHECK
    } asm_state_t;

    // Wrap-around sum of the seven payload words above the checksum field.
    function automatic checksum_t calc_checksum(input flit_t f);
        checksum_t sum;
        sum = '0;
        for (int i = 0; i < FLIT_BYTES/2 - 1; i++) begin
            sum = sum + f[FLIT_WIDTH-1-16*i -: 16];
        end
        return sum;
    endfunction

    function automatic flittype_t get_flittype(input flit_t f);
        return flittype_t'(f[FLIT_WIDTH-5 -: 4]);
    endfunction

endpackage

// File: rtl/flit_checksum.sv
// rtl/flit_checksum.sv - combinational checksum compute and compare for one flit
module flit_checksum
    import uart_flit_assembler_pkg::*;
(
    input  flit_t     flit,
    output checksum_t checksum,
    output logic      match
);

    assign checksum = calc_checksum(flit);
    assign match    = (checksum == flit[15:0]);

endmodule

// File: rtl/uart_flit_assembler.sv
// rtl/uart_flit_assembler.sv - UART byte stream to flit assembler with checksum filter; FLIT_ASM_STATS_EN adds error counters
module uart_flit_assembler
    import uart_flit_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output flit_t       flit_out,
    output logic        flit_valid,
    input  logic        flit_ready,
    output signal_t     err,
    output logic [15:0] chk_err_cnt,
    output logic [15:0] timeout_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    asm_state_t     state, state_nxt;
    logic [3:0]     byte_idx, byte_idx_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    flit_t          shift_reg;
    checksum_t      csum;
    logic           csum_ok;
    logic           is_nope;
    logic           timer_expired;
    logic           load;
    logic           overflow;

    flit_checksum u_checksum (
        .flit     (shift_reg),
        .checksum (csum),
        .match    (csum_ok)
    );

    assign is_nope       = (get_flittype(shift_reg) == NOPE);
    assign timer_expired = (timer == TIMER_MAX);

    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        timer_nxt    = timer;
        load         = 1'b0;
        overflow     = 1'b0;
        case (state)
            ASM_IDLE: begin
                if (rx_valid) begin
                    byte_idx_nxt = 4'd1;
                    timer_nxt    = '0;
                    state_nxt    = ASM_RECV;
                end
            end
            ASM_RECV: begin
                if (rx_valid) begin
                    byte_idx_nxt = byte_idx + 4'd1;
                    timer_nxt    = '0;
                    if (byte_idx == 4'(FLIT_BYTES - 1)) begin
                        state_nxt = ASM_CHECK;
                    end
                end else if (timer_expired) begin
                    byte_idx_nxt = '0;
                    timer_nxt    = '0;
                    state_nxt    = ASM_IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ASM_CHECK: begin
                // Good non-NOPE flit either takes the slot or is dropped as overflow.
                if (csum_ok && !is_nope) begin
                    load     = !flit_valid || flit_ready;
                    overflow = flit_valid && !flit_ready;
                end
                if (rx_valid) begin
                    byte_idx_nxt = 4'd1;
                    timer_nxt    = '0;
                    state_nxt    = ASM_RECV;
                end else begin
                    byte_idx_nxt = '0;
                    state_nxt    = ASM_IDLE;
                end
            end
            default: begin
                byte_idx_nxt = '0;
                timer_nxt    = '0;
                state_nxt    = ASM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ASM_IDLE;
            byte_idx   <= '0;
            timer      <= '0;
            shift_reg  <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            err        <= NO_ERROR;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_idx_nxt;
            timer    <= timer_nxt;
            if (rx_valid) begin
                shift_reg <= {shift_reg[FLIT_WIDTH-9:0], rx_data};
            end
            if (load) begin
                flit_out <= shift_reg;
            end
            flit_valid <= load || (flit_valid && !flit_ready);
            err        <= overflow ? RX_BUFFER_OVERFLOW : NO_ERROR;
        end
    end

`ifdef FLIT_ASM_STATS_EN
    logic [15:0] chk_cnt_q;
    logic [15:0] to_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (state == ASM_CHECK && !csum_ok && chk_cnt_q != 16'hFFFF) begin
                chk_cnt_q <= chk_cnt_q + 16'd1;
            end
            if (state == ASM_RECV && !rx_valid && timer_expired && to_cnt_q != 16'hFFFF) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
        end
    end

    assign chk_err_cnt = chk_cnt_q;
    assign timeout_cnt = to_cnt_q;
`else
    assign chk_err_cnt = 16'h0000;
    assign timeout_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_flit_assembler.sv
// tb/tb_uart_flit_assembler.sv - directed vector bench for uart_flit_assembler
module tb_uart_flit_assembler;
    import uart_flit_assembler_pkg::*;

    localparam int T = 64;
`ifdef FLIT_ASM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [127:0] F_GOOD  = 128'h1000_0000_0000_0000_0000_0000_0000_1000;
    localparam logic [127:0] F_BAD   = 128'h1000_0000_0000_0000_0000_0000_0000_1001;
    localparam logic [127:0] F_NOPE  = 128'h1300_0000_0000_0000_0000_0000_0000_1300;
    localparam logic [127:0] F_BODY  = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_44B8;
    localparam logic [127:0] F_WRAP  = 128'h12FF_FFFF_0001_0000_0000_0000_0000_12FF;
    localparam logic [127:0] F_NOPEB = 128'h1300_0000_0000_0000_0000_0000_0000_1301;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    flit_t       flit_out;
    logic        flit_valid;
    logic        flit_ready;
    signal_t     err;
    logic [15:0] chk_err_cnt;
    logic [15:0] timeout_cnt;

    int checks = 0;
    int errors = 0;
    int exp_chk = 0;
    int exp_to = 0;

    uart_flit_assembler #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .flit_out    (flit_out),
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .err         (err),
        .chk_err_cnt (chk_err_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] flit;
        logic         exp_valid;
        logic         bad;
    } vec_t;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [127:0] f, input int first, input int last);
        for (int k = first; k <= last; k++) send_byte(f[127-8*k -: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_chk_cnt"}, 128'(chk_err_cnt), STATS ? 128'(exp_chk) : 128'h0);
        check({tag, "_to_cnt"}, 128'(timeout_cnt), STATS ? 128'(exp_to) : 128'h0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"good_head", F_GOOD,  1'b1, 1'b0};
        vecs[1] = '{"bad_csum",  F_BAD,   1'b0, 1'b1};
        vecs[2] = '{"nope",      F_NOPE,  1'b0, 1'b0};
        vecs[3] = '{"body",      F_BODY,  1'b1, 1'b0};
        vecs[4] = '{"wrap_csum", F_WRAP,  1'b1, 1'b0};
        vecs[5] = '{"nope_bad",  F_NOPEB, 1'b0, 1'b1};

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; flit_ready = 1'b1;
        idle(2);
        check("rst_valid", 128'(flit_valid), 128'h0);
        check("rst_out", flit_out, 128'h0);
        check("rst_err", 128'(err), 128'h0);
        check_counters("rst");
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 6; i++) begin
            send_bytes(vecs[i].flit, 0, 15);
            check({vecs[i].name, "_lat_n1"}, 128'(flit_valid), 128'h0);
            @(negedge clk);
            check({vecs[i].name, "_valid"}, 128'(flit_valid), 128'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check({vecs[i].name, "_data"}, flit_out, vecs[i].flit);
            check({vecs[i].name, "_err"}, 128'(err), 128'h0);
            @(negedge clk);
            check({vecs[i].name, "_drop"}, 128'(flit_valid), 128'h0);
            if (vecs[i].bad) exp_chk++;
            check_counters(vecs[i].name);
        end

        // Gap of T-1 idle cycles inside a flit must not time out.
        send_bytes(F_BODY, 0, 6);
        idle(T - 1);
        send_bytes(F_BODY, 7, 15);
        @(negedge clk);
        check("gap_valid", 128'(flit_valid), 128'h1);
        check("gap_data", flit_out, F_BODY);
        @(negedge clk);
        check_counters("gap");

        // Gap of T idle cycles discards the partial flit.
        send_bytes(F_BODY, 0, 6);
        idle(T);
        exp_to++;
        check_counters("timeout");
        send_bytes(F_GOOD, 0, 15);
        @(negedge clk);
        check("to_valid", 128'(flit_valid), 128'h1);
        check("to_data", flit_out, F_GOOD);
        @(negedge clk);
        check("to_drop", 128'(flit_valid), 128'h0);

        // Backpressure: second flit overflows while first is held.
        flit_ready = 1'b0;
        send_bytes(F_GOOD, 0, 15);
        send_bytes(F_BODY, 0, 15);
        check("bp_hold_valid", 128'(flit_valid), 128'h1);
        check("bp_err_pre", 128'(err), 128'h0);
        @(negedge clk);
        check("bp_err_pulse", 128'(err), 128'(RX_BUFFER_OVERFLOW));
        check("bp_hold_data", flit_out, F_GOOD);
        @(negedge clk);
        check("bp_err_post", 128'(err), 128'h0);
        check("bp_still_valid", 128'(flit_valid), 128'h1);
        flit_ready = 1'b1;
        check("bp_return_data", flit_out, F_GOOD);
        @(negedge clk);
        check("bp_accepted", 128'(flit_valid), 128'h0);
        idle(3);
        check("bp_no_second", 128'(flit_valid), 128'h0);

        // Accept on the same cycle the next flit is checked.
        flit_ready = 1'b0;
        send_bytes(F_GOOD, 0, 15);
        @(negedge clk);
        check("sim_first_valid", 128'(flit_valid), 128'h1);
        send_bytes(F_WRAP, 0, 15);
        check("sim_held", flit_out, F_GOOD);
        flit_ready = 1'b1;
        @(negedge clk);
        flit_ready = 1'b0;
        check("sim_valid_cont", 128'(flit_valid), 128'h1);
        check("sim_data", flit_out, F_WRAP);
        check("sim_err", 128'(err), 128'h0);
        flit_ready = 1'b1;
        @(negedge clk);
        check("sim_drop", 128'(flit_valid), 128'h0);

        // Asynchronous reset mid-flit with a flit held.
        flit_ready = 1'b0;
        send_bytes(F_BODY, 0, 15);
        @(negedge clk);
        send_bytes(F_GOOD, 0, 8);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 128'(flit_valid), 128'h0);
        check("arst_out", flit_out, 128'h0);
        check("arst_err", 128'(err), 128'h0);
        exp_chk = 0; exp_to = 0;
        check_counters("arst");
        @(negedge clk);
        rst = 1'b0;
        flit_ready = 1'b1;
        send_bytes(F_GOOD, 0, 15);
        @(negedge clk);
        check("post_rst_valid", 128'(flit_valid), 128'h1);
        check("post_rst_data", flit_out, F_GOOD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
